// File: rtl/cpu_trace_monitor.sv
// Instruction trace capture unit: records retired {OP, PC, ALU} samples into a
// circular buffer with breakpoint trigger, post-trigger window and oldest-first readout.
module cpu_trace_monitor #(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [DATA_W-1:0]          PCIN,
  input  logic [DATA_W-1:0]          ALUIN,
  input  logic [OP_W-1:0]            OPIN,
  input  logic                       Valid,
  input  logic                       Arm,
  input  logic                       Stop,
  input  logic                       Mode,
  input  logic                       BpEn,
  input  logic [DATA_W-1:0]          BpAddr,
  input  logic                       RdEn,
  output logic [OP_W+2*DATA_W-1:0]   RdData,
  output logic                       RdValid,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Triggered,
  output logic                       Done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OP_W + 2 * DATA_W;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] POST_INIT = CW'(POST_TRIG);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_POST,
    ST_DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_postcnt;
  logic          r_triggered;
  logic          r_rdValid;
  logic [EW-1:0] r_rdData;
  logic [EW-1:0] r_mem [DEPTH];

  state_t        w_stateNext;
  logic [AW-1:0] w_wptrNext;
  logic [CW-1:0] w_countNext;
  logic [CW-1:0] w_postcntNext;
  logic          w_triggeredNext;
  logic          w_rdValidNext;
  logic [EW-1:0] w_rdDataNext;

  logic          w_write;
  logic          w_trig;
  logic [CW-1:0] w_countInc;
  logic          w_filled;
  logic [AW-1:0] w_rdIdx;

  assign w_write    = ((r_state == ST_CAPTURE) || (r_state == ST_POST)) && Valid;
  assign w_trig     = (r_state == ST_CAPTURE) && Valid && BpEn && (PCIN == BpAddr);
  assign w_countInc = (r_count == FULL) ? r_count : r_count + CW'(1);
  assign w_filled   = Mode && (w_countInc == FULL);
  // Oldest entry sits Count slots behind the write pointer; a full count aliases to wptr itself.
  assign w_rdIdx    = r_wptr - r_count[AW-1:0];

  always_comb begin
    w_stateNext     = r_state;
    w_wptrNext      = r_wptr;
    w_countNext     = r_count;
    w_postcntNext   = r_postcnt;
    w_triggeredNext = r_triggered;
    w_rdValidNext   = 1'b0;
    w_rdDataNext    = r_rdData;

    if (w_write) begin
      w_wptrNext  = r_wptr + AW'(1);
      w_countNext = w_countInc;
    end

    unique case (r_state)
      ST_IDLE: begin
        if (Arm) begin
          w_stateNext     = ST_CAPTURE;
          w_wptrNext      = '0;
          w_countNext     = '0;
          w_triggeredNext = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (w_trig) begin
          w_triggeredNext = 1'b1;
        end
        // Stop outranks the trigger and fill conditions, but the trigger flag still latches.
        if (Stop) begin
          w_stateNext = ST_DONE;
        end else if (w_write && w_filled) begin
          w_stateNext = ST_DONE;
        end else if (w_trig) begin
          if (POST_INIT == '0) begin
            w_stateNext = ST_DONE;
          end else begin
            w_stateNext   = ST_POST;
            w_postcntNext = POST_INIT;
          end
        end
      end
      ST_POST: begin
        if (w_write) begin
          w_postcntNext = r_postcnt - CW'(1);
        end
        if (Stop) begin
          w_stateNext = ST_DONE;
        end else if (w_write && ((r_postcnt == CW'(1)) || w_filled)) begin
          w_stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        if (Arm) begin
          w_stateNext     = ST_CAPTURE;
          w_wptrNext      = '0;
          w_countNext     = '0;
          w_triggeredNext = 1'b0;
        end else if (RdEn && (r_count != '0)) begin
          w_rdValidNext = 1'b1;
          w_rdDataNext  = r_mem[w_rdIdx];
          w_countNext   = r_count - CW'(1);
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_count     <= '0;
      r_postcnt   <= '0;
      r_triggered <= 1'b0;
      r_rdValid   <= 1'b0;
      r_rdData    <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_wptr      <= w_wptrNext;
      r_count     <= w_countNext;
      r_postcnt   <= w_postcntNext;
      r_triggered <= w_triggeredNext;
      r_rdValid   <= w_rdValidNext;
      r_rdData    <= w_rdDataNext;
    end
  end

  // Trace storage is never cleared; Count alone defines which entries are meaningful.
  always_ff @(posedge Clk) begin
    if (w_write) begin
      r_mem[r_wptr] <= {OPIN, PCIN, ALUIN};
    end
  end

  assign RdData    = r_rdData;
  assign RdValid   = r_rdValid;
  assign Count     = r_count;
  assign Triggered = r_triggered;
  assign Done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor at DEPTH=4, POST_TRIG=2: wrap, trigger,
// fill, stop-vs-trigger, arm-vs-read and reset-during-post scenarios.
module tb_cpu_trace_monitor;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int DEPTH  = 4;
  localparam int PT     = 2;
  localparam int EW     = OP_W + 2 * DATA_W;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [DATA_W-1:0] PCIN, ALUIN, BpAddr;
  logic [OP_W-1:0]   OPIN;
  logic              Valid, Arm, Stop, Mode, BpEn, RdEn;
  logic [EW-1:0]     RdData;
  logic              RdValid, Triggered, Done;
  logic [2:0]        Count;

  int compared   = 0;
  int mismatched = 0;

  cpu_trace_monitor #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .POST_TRIG(PT)) dut (
    .Clk(Clk), .Reset(Reset), .PCIN(PCIN), .ALUIN(ALUIN), .OPIN(OPIN), .Valid(Valid),
    .Arm(Arm), .Stop(Stop), .Mode(Mode), .BpEn(BpEn), .BpAddr(BpAddr), .RdEn(RdEn),
    .RdData(RdData), .RdValid(RdValid), .Count(Count), .Triggered(Triggered), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected ALU and opcode are derived from the PC so every entry is self-describing.
  function automatic logic [EW-1:0] entryOf(input logic [DATA_W-1:0] pc);
    entryOf = {pc[OP_W+1:2], pc, pc + 32'h100};
  endfunction

  task automatic applyStimulus(input logic [DATA_W-1:0] pc);
    PCIN  = pc;
    ALUIN = pc + 32'h100;
    OPIN  = pc[OP_W+1:2];
    Valid = 1'b1;
    tick();
    Valid = 1'b0;
  endtask

  task automatic pop();
    RdEn = 1'b1;
    tick();
    RdEn = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (10) tick();
    Reset = 1'b0;
    compared += 4;
    if (Count !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count got %0d want 0", Count); end
    if (Done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", Done); end
    if (RdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rdvalid got %b want 0", RdValid); end
    if (Triggered !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_trig got %b want 0", Triggered); end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] expPc;
    Mode = 1'b0; BpEn = 1'b0;
    Arm = 1'b1; tick(); Arm = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(DATA_W'(4 * i));
    compared += 2;
    if (Count !== 3'd4) begin mismatched++; $display("[TB] FAIL wrap_count got %0d want 4", Count); end
    if (Done !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_notdone got %b want 0", Done); end
    Stop = 1'b1; tick(); Stop = 1'b0;
    compared++;
    if (Done !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_stop_done got %b want 1", Done); end
    for (int k = 0; k < 4; k++) begin
      expPc = DATA_W'(32'h08 + 4 * k);
      pop();
      compared += 3;
      if (RdValid !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_rdvalid%0d got %b want 1", k, RdValid); end
      if (RdData !== entryOf(expPc)) begin mismatched++; $display("[TB] FAIL wrap_rd%0d got %h want %h", k, RdData, entryOf(expPc)); end
      if (Count !== 3'(3 - k)) begin mismatched++; $display("[TB] FAIL wrap_cnt%0d got %0d want %0d", k, Count, 3 - k); end
    end
    pop();
    compared += 2;
    if (RdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_empty_rdvalid got %b want 0", RdValid); end
    if (RdData !== entryOf(32'h14)) begin mismatched++; $display("[TB] FAIL wrap_rd_hold got %h want %h", RdData, entryOf(32'h14)); end
  endtask

  task automatic test_trigger();
    logic [DATA_W-1:0] donePc;
    donePc = 32'hFFFF_FFFF;
    Mode = 1'b0; BpEn = 1'b1; BpAddr = 32'h0C;
    Arm = 1'b1; tick(); Arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(DATA_W'(4 * i));
      if (Done && donePc == 32'hFFFF_FFFF) donePc = DATA_W'(4 * i);
    end
    compared += 3;
    if (donePc !== 32'h14) begin mismatched++; $display("[TB] FAIL trig_done_pc got %h want 00000014", donePc); end
    if (Triggered !== 1'b1) begin mismatched++; $display("[TB] FAIL trig_flag got %b want 1", Triggered); end
    if (Count !== 3'd4) begin mismatched++; $display("[TB] FAIL trig_count got %0d want 4", Count); end
    for (int k = 0; k < 4; k++) begin
      pop();
      compared++;
      if (RdData[2*DATA_W-1:DATA_W] !== DATA_W'(32'h08 + 4 * k)) begin
        mismatched++;
        $display("[TB] FAIL trig_rd%0d got %h want %h", k, RdData[2*DATA_W-1:DATA_W], 32'h08 + 4 * k);
      end
    end
    BpEn = 1'b0;
  endtask

  task automatic test_fill();
    Mode = 1'b1; BpEn = 1'b0;
    Arm = 1'b1; tick(); Arm = 1'b0;
    compared += 2;
    if (Triggered !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_arm_trig got %b want 0", Triggered); end
    if (Count !== 3'd0) begin mismatched++; $display("[TB] FAIL fill_arm_count got %0d want 0", Count); end
    applyStimulus(32'h40);
    applyStimulus(32'h44);
    tick();
    compared++;
    if (Count !== 3'd2) begin mismatched++; $display("[TB] FAIL fill_gap_count got %0d want 2", Count); end
    applyStimulus(32'h48);
    compared++;
    if (Done !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_early_done got %b want 0", Done); end
    applyStimulus(32'h4C);
    compared++;
    if (Done !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_done got %b want 1", Done); end
    applyStimulus(32'h50);
    compared++;
    if (Count !== 3'd4) begin mismatched++; $display("[TB] FAIL fill_count got %0d want 4", Count); end
    for (int k = 0; k < 4; k++) begin
      pop();
      compared++;
      if (RdData !== entryOf(DATA_W'(32'h40 + 4 * k))) begin
        mismatched++;
        $display("[TB] FAIL fill_rd%0d got %h want %h", k, RdData, entryOf(DATA_W'(32'h40 + 4 * k)));
      end
    end
    Mode = 1'b0;
  endtask

  task automatic test_stop_and_bp();
    BpEn = 1'b1; BpAddr = 32'h08;
    Arm = 1'b1; tick(); Arm = 1'b0;
    applyStimulus(32'h00);
    applyStimulus(32'h04);
    Stop = 1'b1;
    applyStimulus(32'h08);
    Stop = 1'b0;
    compared += 3;
    if (Done !== 1'b1) begin mismatched++; $display("[TB] FAIL stopbp_done got %b want 1", Done); end
    if (Triggered !== 1'b1) begin mismatched++; $display("[TB] FAIL stopbp_trig got %b want 1", Triggered); end
    if (Count !== 3'd3) begin mismatched++; $display("[TB] FAIL stopbp_count got %0d want 3", Count); end
    pop();
    compared++;
    if (RdData !== entryOf(32'h00)) begin mismatched++; $display("[TB] FAIL stopbp_rd0 got %h want %h", RdData, entryOf(32'h00)); end
    Arm = 1'b1; RdEn = 1'b1; tick(); Arm = 1'b0; RdEn = 1'b0;
    compared += 3;
    if (RdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL armrd_rdvalid got %b want 0", RdValid); end
    if (Count !== 3'd0) begin mismatched++; $display("[TB] FAIL armrd_count got %0d want 0", Count); end
    if (Done !== 1'b0) begin mismatched++; $display("[TB] FAIL armrd_done got %b want 0", Done); end
  endtask

  task automatic test_reset_in_post();
    applyStimulus(32'h00);
    applyStimulus(32'h04);
    applyStimulus(32'h08);
    compared += 2;
    if (Triggered !== 1'b1 || Done !== 1'b0) begin
      mismatched++; $display("[TB] FAIL post_entry got trig=%b done=%b want trig=1 done=0", Triggered, Done);
    end
    if (Count !== 3'd3) begin mismatched++; $display("[TB] FAIL post_count got %0d want 3", Count); end
    Reset = 1'b1; tick(); Reset = 1'b0;
    compared += 4;
    if (Count !== 3'd0) begin mismatched++; $display("[TB] FAIL rstpost_count got %0d want 0", Count); end
    if (Triggered !== 1'b0) begin mismatched++; $display("[TB] FAIL rstpost_trig got %b want 0", Triggered); end
    if (Done !== 1'b0) begin mismatched++; $display("[TB] FAIL rstpost_done got %b want 0", Done); end
    if (RdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstpost_rdvalid got %b want 0", RdValid); end
    Stop = 1'b1;
    applyStimulus(32'h0C);
    Stop = 1'b0;
    compared += 2;
    if (Count !== 3'd0) begin mismatched++; $display("[TB] FAIL idle_valid_count got %0d want 0", Count); end
    if (Done !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_stop_done got %b want 0", Done); end
  endtask

  initial begin
    Reset = 1'b1; PCIN = '0; ALUIN = '0; OPIN = '0; BpAddr = '0;
    Valid = 1'b0; Arm = 1'b0; Stop = 1'b0; Mode = 1'b0; BpEn = 1'b0; RdEn = 1'b0;
    #2;
    test_reset();
    test_wrap();
    test_trigger();
    test_fill();
    test_stop_and_bp();
    test_reset_in_post();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
